// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM-subset datapath: condition codes, NZCV flag
// bit positions and FlagW bit positions.
package cpu_pkg;

   typedef logic [3:0] cond_t;

   localparam cond_t COND_EQ = 4'b0000;
   localparam cond_t COND_NE = 4'b0001;
   localparam cond_t COND_CS = 4'b0010;
   localparam cond_t COND_CC = 4'b0011;
   localparam cond_t COND_MI = 4'b0100;
   localparam cond_t COND_PL = 4'b0101;
   localparam cond_t COND_VS = 4'b0110;
   localparam cond_t COND_VC = 4'b0111;
   localparam cond_t COND_HI = 4'b1000;
   localparam cond_t COND_LS = 4'b1001;
   localparam cond_t COND_GE = 4'b1010;
   localparam cond_t COND_LT = 4'b1011;
   localparam cond_t COND_GT = 4'b1100;
   localparam cond_t COND_LE = 4'b1101;
   localparam cond_t COND_AL = 4'b1110;
   localparam cond_t COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: maps the 4-bit condition field and the
// registered NZCV flags to the condition-passed bit.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = ~z & (n == v);
         COND_LE: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         // NV is reserved: squash rather than execute
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: NZCV flag register, condition evaluation and
// write-enable gating. Optional perf counters under COND_LOGIC_PERF_CNT_EN.
module cond_logic
   import cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             InstrValid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
`ifdef COND_LOGIC_PERF_CNT_EN
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SquashCount,
`endif
   output logic [3:0]       Flags
);

   logic [3:0] flag_reg;
   logic       exec;

   cond_check u_cond_check (
      .Cond   (Cond),
      .Flags  (flag_reg),
      .CondEx (CondEx)
   );

   assign exec = InstrValid & CondEx;

   // Flags are visible to the next instruction only; reset wins over update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flag_reg <= 4'b0000;
      end else if (exec) begin
         if (FlagW[FLAGW_NZ]) begin
            flag_reg[FLAG_N] <= ALUFlags[FLAG_N];
            flag_reg[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (FlagW[FLAGW_CV]) begin
            flag_reg[FLAG_C] <= ALUFlags[FLAG_C];
            flag_reg[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   assign Flags    = flag_reg;
   assign PCSrc    = rst_n & exec & PCS;
   assign RegWrite = rst_n & exec & RegW & ~NoWrite;
   assign MemWrite = rst_n & exec & MemW;

`ifdef COND_LOGIC_PERF_CNT_EN
   logic [CNT_W-1:0] exec_cnt;
   logic [CNT_W-1:0] squash_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exec_cnt   <= '0;
         squash_cnt <= '0;
      end else if (InstrValid) begin
         if (CondEx) exec_cnt   <= exec_cnt + 1'b1;
         else        squash_cnt <= squash_cnt + 1'b1;
      end
   end

   assign ExecCount   = exec_cnt;
   assign SquashCount = squash_cnt;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Directed testbench for cond_logic; counter checks active with COND_LOGIC_PERF_CNT_EN.
module tb_cond_logic;

   localparam int CNT_W = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       InstrValid;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;
`ifdef COND_LOGIC_PERF_CNT_EN
   logic [CNT_W-1:0] ExecCount, SquashCount;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cond_logic #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .InstrValid (InstrValid),
      .Cond       (Cond),
      .ALUFlags   (ALUFlags),
      .FlagW      (FlagW),
      .PCS        (PCS),
      .RegW       (RegW),
      .MemW       (MemW),
      .NoWrite    (NoWrite),
      .PCSrc      (PCSrc),
      .RegWrite   (RegWrite),
      .MemWrite   (MemWrite),
      .CondEx     (CondEx),
`ifdef COND_LOGIC_PERF_CNT_EN
      .ExecCount  (ExecCount),
      .SquashCount(SquashCount),
`endif
      .Flags      (Flags)
   );

   // Reference condition table written directly from the ISA definition
   function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      InstrValid = 1'b0; Cond = 4'he; ALUFlags = 4'h0; FlagW = 2'b00;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
   endtask

   // Loads an arbitrary flag value through an always-executed instruction
   task automatic load_flags(input logic [3:0] f);
      idle();
      InstrValid = 1'b1; Cond = 4'he; FlagW = 2'b11; ALUFlags = f;
      tick();
      idle();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle();
      InstrValid = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
      Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'hf;
      tick(); tick();
      n_cmp++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin n_fail++;
         $display("FAIL reset_gate: got %b want 000", {PCSrc, RegWrite, MemWrite}); end
      n_cmp++; if (Flags !== 4'b0000) begin n_fail++;
         $display("FAIL reset_flags: got %b want 0000", Flags); end
      n_cmp++; if (CondEx !== 1'b1) begin n_fail++;
         $display("FAIL reset_condex_al: got %b want 1", CondEx); end
      idle(); rst_n = 1'b1;
      Cond = 4'h0; #1;
      n_cmp++; if (CondEx !== 1'b0) begin n_fail++;
         $display("FAIL post_reset_eq: got %b want 0", CondEx); end
      Cond = 4'h1; #1;
      n_cmp++; if (CondEx !== 1'b1) begin n_fail++;
         $display("FAIL post_reset_ne: got %b want 1", CondEx); end
      tick();
   endtask

   task automatic test_flag_set_use();
      idle();
      InstrValid = 1'b1; Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'b0100;
      NoWrite = 1'b1; RegW = 1'b1; #1;
      n_cmp++; if (RegWrite !== 1'b0) begin n_fail++;
         $display("FAIL cmp_regwrite: got %b want 0", RegWrite); end
      tick();
      n_cmp++; if (Flags !== 4'b0100) begin n_fail++;
         $display("FAIL cmp_flags: got %b want 0100", Flags); end
      idle(); InstrValid = 1'b1; Cond = 4'h0; RegW = 1'b1; #1;
      n_cmp++; if (RegWrite !== 1'b1) begin n_fail++;
         $display("FAIL eq_regwrite: got %b want 1", RegWrite); end
      tick();
      idle(); InstrValid = 1'b1; Cond = 4'h1; RegW = 1'b1; MemW = 1'b1; #1;
      n_cmp++; if ({RegWrite, MemWrite} !== 2'b00) begin n_fail++;
         $display("FAIL ne_writes: got %b want 00", {RegWrite, MemWrite}); end
      tick(); idle();
   endtask

   task automatic test_partial_update();
      load_flags(4'hf);
      InstrValid = 1'b1; Cond = 4'he; FlagW = 2'b10; ALUFlags = 4'h0;
      tick(); idle();
      n_cmp++; if (Flags !== 4'b0011) begin n_fail++;
         $display("FAIL partial_flags: got %b want 0011", Flags); end
      Cond = 4'ha; #1;
      n_cmp++; if (CondEx !== 1'b0) begin n_fail++;
         $display("FAIL partial_ge: got %b want 0", CondEx); end
      Cond = 4'hb; #1;
      n_cmp++; if (CondEx !== 1'b1) begin n_fail++;
         $display("FAIL partial_lt: got %b want 1", CondEx); end
      load_flags(4'h0);
      InstrValid = 1'b1; Cond = 4'he; FlagW = 2'b01; ALUFlags = 4'hf;
      tick(); idle();
      n_cmp++; if (Flags !== 4'b0011) begin n_fail++;
         $display("FAIL partial_cv_flags: got %b want 0011", Flags); end
   endtask

   task automatic test_squash_bubble();
      load_flags(4'h0);
      InstrValid = 1'b1; Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'hf;
      PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; #1;
      n_cmp++; if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin n_fail++;
         $display("FAIL squash_outs: got %b want 0000", {CondEx, PCSrc, RegWrite, MemWrite}); end
      tick();
      n_cmp++; if (Flags !== 4'b0000) begin n_fail++;
         $display("FAIL squash_flags: got %b want 0000", Flags); end
      InstrValid = 1'b0; Cond = 4'he; #1;
      n_cmp++; if ({PCSrc, RegWrite, MemWrite} !== 3'b000) begin n_fail++;
         $display("FAIL bubble_outs: got %b want 000", {PCSrc, RegWrite, MemWrite}); end
      tick();
      n_cmp++; if (Flags !== 4'b0000) begin n_fail++;
         $display("FAIL bubble_flags: got %b want 0000", Flags); end
      InstrValid = 1'b1; FlagW = 2'b00; #1;
      n_cmp++; if ({PCSrc, RegWrite, MemWrite} !== 3'b111) begin n_fail++;
         $display("FAIL flagw0_outs: got %b want 111", {PCSrc, RegWrite, MemWrite}); end
      tick();
      n_cmp++; if (Flags !== 4'b0000) begin n_fail++;
         $display("FAIL flagw0_flags: got %b want 0000", Flags); end
      idle();
   endtask

   task automatic test_back_to_back();
      load_flags(4'h0);
      InstrValid = 1'b1; Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'b0100;
      tick();
      Cond = 4'h0; ALUFlags = 4'b1000; #1;
      n_cmp++; if (CondEx !== 1'b1) begin n_fail++;
         $display("FAIL b2b_eq_after_set: got %b want 1", CondEx); end
      tick();
      n_cmp++; if (Flags !== 4'b1000) begin n_fail++;
         $display("FAIL b2b_flags: got %b want 1000", Flags); end
      Cond = 4'h0; ALUFlags = 4'b0000; #1;
      n_cmp++; if (CondEx !== 1'b0) begin n_fail++;
         $display("FAIL b2b_eq_cleared: got %b want 0", CondEx); end
      tick();
      n_cmp++; if (Flags !== 4'b1000) begin n_fail++;
         $display("FAIL b2b_squash_hold: got %b want 1000", Flags); end
      Cond = 4'h4; FlagW = 2'b00; #1;
      n_cmp++; if (CondEx !== 1'b1) begin n_fail++;
         $display("FAIL b2b_mi: got %b want 1", CondEx); end
      tick(); idle();
   endtask

   task automatic test_reset_mid_stream();
      load_flags(4'h5);
      InstrValid = 1'b1; Cond = 4'he; FlagW = 2'b11; ALUFlags = 4'hf; PCS = 1'b1;
      rst_n = 1'b0; #1;
      n_cmp++; if (PCSrc !== 1'b0) begin n_fail++;
         $display("FAIL midrst_pcsrc: got %b want 0", PCSrc); end
      tick();
      n_cmp++; if (Flags !== 4'b0000) begin n_fail++;
         $display("FAIL midrst_flags: got %b want 0000", Flags); end
      idle(); rst_n = 1'b1; tick();
   endtask

   task automatic test_cond_sweep();
      logic exp;
      for (int f = 0; f < 16; f++) begin
         load_flags(4'(f));
         for (int c = 0; c < 16; c++) begin
            Cond = 4'(c); #1;
            exp = ref_cond(4'(c), 4'(f));
            n_cmp++; if (CondEx !== exp) begin n_fail++;
               $display("FAIL sweep cond=%h flags=%b: got %b want %b", c, f[3:0], CondEx, exp); end
         end
      end
      idle();
   endtask

`ifdef COND_LOGIC_PERF_CNT_EN
   task automatic test_perf_cnt();
      idle(); rst_n = 1'b0; tick(); rst_n = 1'b1;
      n_cmp++; if ({ExecCount, SquashCount} !== 8'h00) begin n_fail++;
         $display("FAIL cnt_reset: got %h/%h want 0/0", ExecCount, SquashCount); end
      InstrValid = 1'b1; Cond = 4'he;
      for (int i = 0; i < 20; i++) tick();
      n_cmp++; if (ExecCount !== 4'd4) begin n_fail++;
         $display("FAIL cnt_exec_wrap: got %0d want 4", ExecCount); end
      Cond = 4'hf;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++; if (SquashCount !== 4'd3) begin n_fail++;
         $display("FAIL cnt_squash: got %0d want 3", SquashCount); end
      n_cmp++; if (ExecCount !== 4'd4) begin n_fail++;
         $display("FAIL cnt_exec_hold: got %0d want 4", ExecCount); end
      InstrValid = 1'b0; Cond = 4'he;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++; if ({ExecCount, SquashCount} !== {4'd4, 4'd3}) begin n_fail++;
         $display("FAIL cnt_bubble: got %0d/%0d want 4/3", ExecCount, SquashCount); end
      InstrValid = 1'b1; rst_n = 1'b0; tick(); rst_n = 1'b1; idle();
      n_cmp++; if ({ExecCount, SquashCount} !== 8'h00) begin n_fail++;
         $display("FAIL cnt_rst_hold: got %0d/%0d want 0/0", ExecCount, SquashCount); end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      idle();
      #1;
      test_reset();
      test_flag_set_use();
      test_partial_update();
      test_squash_bubble();
      test_back_to_back();
      test_reset_mid_stream();
      test_cond_sweep();
`ifdef COND_LOGIC_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage directly downstream of the main/ALU decoders in the single-cycle ARM-subset datapath.
- Holds the architectural NZCV flag register and evaluates the instruction's 4-bit condition field against it.
- Gates the decoder's write enables (PCS, RegW, MemW) so that squashed instructions have no architectural side effects.
- Updates flags from the ALU when the instruction executes and its FlagW bits request it.

Parameters:
- CNT_W, 32, width of the optional executed/squashed instruction counters.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  synchronous reset, active-low
- InstrValid  in  1  current cycle carries a real instruction; 0 = bubble/stall, no state change
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle
- FlagW  in  2  from ALU decoder; bit1 = update N,Z; bit0 = update C,V
- PCS  in  1  decoder requests a PC write (branch, or write to R15)
- RegW  in  1  decoder register-write request
- MemW  in  1  decoder memory-write request
- NoWrite  in  1  compare-class op (CMP/CMN); suppresses the register write
- PCSrc  out  1  PCS & CondEx & InstrValid
- RegWrite  out  1  RegW & CondEx & InstrValid & ~NoWrite
- MemWrite  out  1  MemW & CondEx & InstrValid
- CondEx  out  1  condition passed, evaluated against the registered flags
- Flags  out  4  registered {N,Z,C,V}

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - Flags <= 4'b0000; optional counters <= 0.
  - While rst_n=0, PCSrc, RegWrite and MemWrite are forced to 0.
  - CondEx is still evaluated combinationally.
- CondEx is combinational from Cond and the registered Flags. It is never computed from ALUFlags of the same cycle.
- Condition codes:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111 (reserved/NV): 0, so the instruction is squashed.
- Flag update at the rising edge, when rst_n=1 and InstrValid=1 and CondEx=1:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - Unselected bits hold their value.
  - Latency is 1 cycle: the next instruction sees the new flags. The current instruction never sees its own flags.
- Squashed instruction (CondEx=0) or bubble (InstrValid=0): flags hold and all gated outputs are 0.
- FlagW=2'b00 with CondEx=1: flags hold; gated outputs still follow the decoder.
- Back-to-back flag-setting instructions: each evaluates against the flags left by its predecessor.
- Reset asserted mid-stream overrides any same-edge flag update.
- No X propagation: the Cond decode is full-case, with a default of 0.

Optional Feature:
- Macro: COND_LOGIC_PERF_CNT_EN.
- When defined, two extra output ports exist:
  - ExecCount [CNT_W-1:0]: increments each edge with InstrValid&CondEx.
  - SquashCount [CNT_W-1:0]: increments each edge with InstrValid&~CondEx.
- Counter rules:
  - Both counters wrap modulo 2^CNT_W.
  - Both reset to 0.
  - Neither counts while rst_n=0 or InstrValid=0.
- When undefined: the ports and counters are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - cond_t localparams for the 16 condition codes (COND_EQ..COND_NV);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the FlagW bit positions.
- One natural sub-module: cond_check. It is purely combinational, mapping Cond and Flags to CondEx.
- The flag register, output gating and counters stay in cond_logic.

Test Plan:
- Reset: rst_n=0 for 2 cycles with PCS=RegW=MemW=1, Cond=1110 -> all gated outputs 0, Flags=0000. Release reset -> Cond=0000 gives CondEx=0, Cond=0001 gives CondEx=1.
- Flag set then use:
  - Cycle 1 (CMP): Cond=1110, FlagW=11, ALUFlags=0100, NoWrite=1, RegW=1 -> RegWrite=0, Flags=0100 after the edge.
  - Cycle 2: Cond=0000, RegW=1 -> RegWrite=1.
  - Cycle 3: Cond=0001 -> RegWrite=0, MemWrite=0.
- Partial update: start from Flags=1111; apply FlagW=10, ALUFlags=0000 -> Flags=0011. Then Cond=1010 (GE, N==V with N=0,V=1) -> CondEx=0.
- Squash/bubble hold:
  - Flags=0000, Cond=0000, FlagW=11, ALUFlags=1111 -> CondEx=0, Flags stay 0000.
  - InstrValid=0 with Cond=1110, FlagW=11 -> Flags unchanged, PCSrc=0.
- Exhaustive condition sweep: all 16 Cond values × all 16 flag states against the reference table above. Cond=1111 always gives CondEx=0.
- COND_LOGIC_PERF_CNT_EN with CNT_W=4:
  - 20 valid executed instructions -> ExecCount=4 (wrap).
  - 3 squashed -> SquashCount=3.
  - Bubbles change neither counter.
